// File: rtl/scsi_io_arbiter.sv
// scsi_io_arbiter: round-robin owner of the shared IO sector channel, held per sector, with grant timeout
module scsi_io_arbiter #(
  parameter int NUM_TGT = 2,
  parameter int TO_BITS = 20
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_TGT-1:0]     tgt_rd,
  input  logic [NUM_TGT-1:0]     tgt_wr,
  input  logic [32*NUM_TGT-1:0]  tgt_lba,
  input  logic [8*NUM_TGT-1:0]   tgt_buff_din,
  output logic [NUM_TGT-1:0]     tgt_ack,
  output logic [NUM_TGT-1:0]     tgt_buff_wr,
  output logic                   io_rd,
  output logic                   io_wr,
  output logic [31:0]            io_lba,
  input  logic                   io_ack,
  input  logic                   sd_buff_wr,
  output logic [7:0]             sd_buff_din,
  output logic [2:0]             owner,
  output logic                   busy,
  output logic                   timeout
);
  localparam int IW = NUM_TGT > 1 ? $clog2(NUM_TGT) : 1;
  // abort on the cycle that would bring the counter to all-ones: 2**TO_BITS-1 grant cycles
  localparam logic [TO_BITS-1:0] CNT_LAST = {{(TO_BITS-1){1'b1}}, 1'b0};
  typedef enum logic [1:0] {IDLE, GRANT, XFER, DONE} state_t;
  state_t state;
  logic [IW-1:0] oi, rr_ptr, pick;
  logic [TO_BITS-1:0] cnt;
  logic [NUM_TGT-1:0] pend;
  int j;
  assign pend = tgt_rd | tgt_wr;
  // scan downward so the pending index closest to rr_ptr is the last written
  always_comb begin
    pick = '0;
    j = 0;
    for (int k = NUM_TGT - 1; k >= 0; k--) begin
      j = (int'(rr_ptr) + k) % NUM_TGT;
      if (pend[j]) pick = IW'(j);
    end
  end
  assign owner = 3'(oi);
  assign busy = state != IDLE;
  assign sd_buff_din = tgt_buff_din[8*oi +: 8];
  assign tgt_ack = (state == XFER && io_ack) ? NUM_TGT'(1) << oi : '0;
  assign tgt_buff_wr = (state == XFER && sd_buff_wr) ? NUM_TGT'(1) << oi : '0;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      io_rd <= 1'b0;
      io_wr <= 1'b0;
      io_lba <= '0;
      oi <= '0;
      rr_ptr <= '0;
      timeout <= 1'b0;
      cnt <= '0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: if (|pend) begin
          oi <= pick;
          io_lba <= tgt_lba[32*pick +: 32];
          io_rd <= tgt_rd[pick];
          io_wr <= ~tgt_rd[pick];
          cnt <= '0;
          state <= GRANT;
        end
        GRANT: begin
          cnt <= cnt + TO_BITS'(cnt != '1);
          if (io_ack) begin
            io_rd <= 1'b0;
            io_wr <= 1'b0;
            state <= XFER;
          end else if (!pend[oi] || cnt == CNT_LAST) begin
            io_rd <= 1'b0;
            io_wr <= 1'b0;
            timeout <= pend[oi];
            state <= DONE;
          end
        end
        XFER: if (!io_ack) state <= DONE;
        DONE: begin
          rr_ptr <= (oi == IW'(NUM_TGT - 1)) ? '0 : oi + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_scsi_io_arbiter.sv
// tb_scsi_io_arbiter: directed scenarios plus randomized transfers against a transaction-level arbitration model
module tb_scsi_io_arbiter;
  localparam int N = 2;
  logic clk = 0, reset_n = 0;
  logic [N-1:0] rd = '0, wr = '0;
  logic [32*N-1:0] lba = '0;
  logic [8*N-1:0] din = '0;
  logic ack = 0, sbw = 0;
  logic [N-1:0] tgt_ack, tgt_buff_wr;
  logic io_rd, io_wr, busy, timeout;
  logic [31:0] io_lba;
  logic [7:0] sd_buff_din;
  logic [2:0] owner;
  int n_chk = 0, n_fail = 0;
  int rr = 0;

  scsi_io_arbiter #(.NUM_TGT(N), .TO_BITS(4)) dut (
    .clk(clk), .reset_n(reset_n), .tgt_rd(rd), .tgt_wr(wr), .tgt_lba(lba),
    .tgt_buff_din(din), .tgt_ack(tgt_ack), .tgt_buff_wr(tgt_buff_wr),
    .io_rd(io_rd), .io_wr(io_wr), .io_lba(io_lba), .io_ack(ack),
    .sd_buff_wr(sbw), .sd_buff_din(sd_buff_din), .owner(owner),
    .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // first pending target scanning from the round-robin start point
  function automatic int pick();
    for (int k = 0; k < N; k++) begin
      if (rd[(rr + k) % N] | wr[(rr + k) % N]) return (rr + k) % N;
    end
    return 0;
  endfunction

  // one complete sector transfer acting as IO controller and requesting target
  task automatic xfer(input bit clr, input bit stale, input int nstr);
    int o, g, c1, de;
    logic [31:0] el;
    logic ed;
    o = pick();
    el = lba[32*o +: 32];
    ed = rd[o];
    if (stale) ack = 1;
    g = 0;
    while (!(busy && (io_rd || io_wr)) && g < 8) begin
      step();
      g++;
    end
    chk("grant_seen", g < 8, 1);
    if (g >= 8) begin
      ack = 0;
      return;
    end
    chk("owner", owner, o);
    chk("io_rd", io_rd, ed);
    chk("io_wr", io_wr, !ed);
    chk("io_lba", io_lba, el);
    chk("ack_gated_grant", tgt_ack, 0);
    lba[32*o +: 32] = $urandom();
    ack = 1;
    step();
    chk("xfer_ack", tgt_ack, N'(1) << o);
    chk("req_dropped", {io_rd, io_wr}, 0);
    chk("lba_held", io_lba, el);
    if (clr) begin
      if (ed) rd[o] = 0;
      else wr[o] = 0;
    end
    c1 = 0;
    de = 0;
    for (int s = 0; s < nstr; s++) begin
      sbw = 1;
      din = (8*N)'($urandom());
      #1;
      if (tgt_buff_wr === N'(1) << o) c1++;
      if (sd_buff_din !== din[8*o +: 8]) de++;
      step();
      sbw = 0;
      step();
    end
    chk("strobes", c1, nstr);
    chk("din_mux", de, 0);
    ack = 0;
    step();
    chk("done_busy", busy, 1);
    chk("done_ack", tgt_ack, 0);
    step();
    chk("idle", busy, 0);
    rr = (o + 1) % N;
  endtask

  initial begin
    int c;
    // reset held with requests and ack active
    rd = 2'b11;
    ack = 1;
    repeat (3) step();
    chk("rst_io", {io_rd, io_wr}, 0);
    chk("rst_ack", tgt_ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_lba", io_lba, 0);
    rd = 0;
    ack = 0;
    reset_n = 1;
    step();
    // single read of target 1, full 512-byte sector
    rd = 2'b10;
    lba[63:32] = 32'h0000_1234;
    step();
    chk("single_busy", busy, 1);
    xfer(1, 0, 512);
    // continuous contention: 0,1,0,1
    rd = 2'b11;
    lba = {32'hbbbb_0001, 32'haaaa_0000};
    for (int i = 0; i < 4; i++) xfer(0, 0, 2);
    rd = 0;
    // read and write from the same target: read first, write next
    rd = 2'b01;
    wr = 2'b01;
    xfer(1, 0, 1);
    xfer(1, 0, 1);
    // grant timeout on a write that never sees ack
    wr = 2'b01;
    step();
    chk("to_grant_wr", io_wr, 1);
    rd[1] = 1;
    c = 0;
    while (io_wr && c < 40) begin
      c++;
      step();
    end
    chk("to_len", c, 15);
    chk("to_pulse", timeout, 1);
    chk("to_busy", busy, 1);
    rr = 1;
    step();
    chk("to_pulse_end", timeout, 0);
    xfer(1, 0, 3);
    wr = 0;
    step();
    // withdraw before ack: no timeout
    rd = 2'b01;
    step();
    chk("wd_grant", {owner, io_rd}, {3'd0, 1'b1});
    rd = 0;
    step();
    chk("wd_drop", io_rd, 0);
    chk("wd_no_timeout", timeout, 0);
    chk("wd_busy", busy, 1);
    step();
    chk("wd_idle", busy, 0);
    rr = 1;
    // reset during transfer abandons it and restarts round-robin at 0
    rd = 2'b10;
    step();
    ack = 1;
    step();
    chk("mid_ack", tgt_ack, 2'b10);
    reset_n = 0;
    step();
    chk("mid_rst_ack", tgt_ack, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_owner", owner, 0);
    reset_n = 1;
    ack = 0;
    rd = 0;
    rr = 0;
    step();
    rd = 2'b11;
    xfer(1, 0, 1);
    // randomized traffic, including stale ack at grant
    for (int i = 0; i < 30; i++) begin
      rd |= N'($urandom());
      wr |= N'($urandom());
      if ((rd | wr) == 0) rd[$urandom % N] = 1;
      lba = {32'($urandom()), 32'($urandom())};
      xfer(1, ($urandom % 4) == 0, 1 + $urandom % 6);
    end
    rd = 0;
    wr = 0;
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
